square_wave_gen: RTL and testbench

SQUARE_WAVE_GEN -- requirements
Module: square_wave_gen

---
 rtl/square_wave_gen.sv | 134 +++++++++++++
 tb/tb_square_wave_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_gen.sv
// rtl/square_wave_gen.sv - pulse (square wave) channel with duty, length and frequency timer
module square_wave_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        slow_clk_en,
    input  logic        cpu_en,
    input  logic        clk256_en,
    input  logic [7:0]  duty_len_data,
    input  logic        duty_len_write,
    input  logic [7:0]  freq_lo_data,
    input  logic        freq_lo_write,
    input  logic [7:0]  freq_hi_data,
    input  logic        freq_hi_write,
    input  logic [10:0] sweep_new_freq,
    input  logic        do_freq_sweep,
    output logic [10:0] freq,
    output logic        init,
    output logic [1:0]  duty,
    output logic        length_enable,
    output logic        enabled,
    output logic [2:0]  duty_pos,
    output logic        wave_out
);

    logic [10:0] timer_cnt;
    logic [6:0]  length_cnt;
    logic [10:0] freq_next;
    logic [7:0]  pattern;
    logic        nr11_wr;
    logic        nr13_wr;
    logic        nr14_wr;
    logic        trigger;
    logic        length_tick;
    logic        timer_tick;
    logic        unused_hi_bits;

    assign nr11_wr        = cpu_en & duty_len_write;
    assign nr13_wr        = cpu_en & freq_lo_write;
    assign nr14_wr        = cpu_en & freq_hi_write;
    assign trigger        = nr14_wr & freq_hi_data[7];
    assign length_tick    = slow_clk_en & clk256_en & length_enable & (length_cnt != 7'd0);
    assign timer_tick     = slow_clk_en & enabled;
    assign unused_hi_bits = ^freq_hi_data[5:3];

    // Next frequency: CPU writes own the register when present, sweep loads only otherwise
    always_comb begin
        freq_next = freq;
        if (nr13_wr || nr14_wr) begin
            if (nr13_wr) begin
                freq_next[7:0] = freq_lo_data;
            end
            if (nr14_wr) begin
                freq_next[10:8] = freq_hi_data[2:0];
            end
        end else if (do_freq_sweep) begin
            freq_next = sweep_new_freq;
        end
    end

    // Register file: frequency, duty, length enable and the one-clk init pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            freq          <= 11'd0;
            duty          <= 2'd0;
            length_enable <= 1'b0;
            init          <= 1'b0;
        end else begin
            freq <= freq_next;
            init <= trigger;
            if (nr11_wr) begin
                duty <= duty_len_data[7:6];
            end
            if (nr14_wr) begin
                length_enable <= freq_hi_data[6];
            end
        end
    end

    // Frequency timer: counts up to 0x7FF, then reloads and advances the waveform step
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_cnt <= 11'd0;
            duty_pos  <= 3'd0;
        end else if (trigger) begin
            timer_cnt <= freq_next;
        end else if (timer_tick) begin
            if (timer_cnt == 11'h7FF) begin
                timer_cnt <= freq;
                duty_pos  <= duty_pos + 3'd1;
            end else begin
                timer_cnt <= timer_cnt + 11'd1;
            end
        end
    end

    // Length counter and channel enable; writes take precedence over the length tick
    always_ff @(posedge clk) begin
        if (reset) begin
            length_cnt <= 7'd0;
            enabled    <= 1'b0;
        end else begin
            if (nr11_wr) begin
                length_cnt <= 7'd64 - {1'b0, duty_len_data[5:0]};
            end else if (trigger) begin
                if (length_cnt == 7'd0) begin
                    length_cnt <= 7'd64;
                end
            end else if (length_tick) begin
                length_cnt <= length_cnt - 7'd1;
            end

            if (trigger) begin
                enabled <= 1'b1;
            end else if (length_tick && !nr11_wr && length_cnt == 7'd1) begin
                enabled <= 1'b0;
            end
        end
    end

    // Duty pattern lookup, bit n is the output for waveform step n
    always_comb begin
        pattern = 8'h80;
        case (duty)
            2'd0: pattern = 8'h80;
            2'd1: pattern = 8'h81;
            2'd2: pattern = 8'hE1;
            2'd3: pattern = 8'h7E;
            default: pattern = 8'h80;
        endcase
    end

    assign wave_out = pattern[duty_pos] & enabled;

endmodule

// File: tb/tb_square_wave_gen.sv
// tb/tb_square_wave_gen.sv - randomized model-checked bench for square_wave_gen
module tb_square_wave_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        slow_clk_en;
    logic        cpu_en;
    logic        clk256_en;
    logic [7:0]  duty_len_data;
    logic        duty_len_write;
    logic [7:0]  freq_lo_data;
    logic        freq_lo_write;
    logic [7:0]  freq_hi_data;
    logic        freq_hi_write;
    logic [10:0] sweep_new_freq;
    logic        do_freq_sweep;
    logic [10:0] freq;
    logic        init;
    logic [1:0]  duty;
    logic        length_enable;
    logic        enabled;
    logic [2:0]  duty_pos;
    logic        wave_out;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state: m_left is the number of enabled ticks until the next step
    int m_freq, m_duty, m_len, m_lenen, m_en, m_pos, m_init, m_left;
    string pat [4] = '{"00000001", "10000001", "10000111", "01111110"};
    int wave41 [8] = '{1, 0, 0, 0, 0, 1, 1, 1};

    always #5 clk = ~clk;

    square_wave_gen dut (
        .clk            (clk),
        .reset          (reset),
        .slow_clk_en    (slow_clk_en),
        .cpu_en         (cpu_en),
        .clk256_en      (clk256_en),
        .duty_len_data  (duty_len_data),
        .duty_len_write (duty_len_write),
        .freq_lo_data   (freq_lo_data),
        .freq_lo_write  (freq_lo_write),
        .freq_hi_data   (freq_hi_data),
        .freq_hi_write  (freq_hi_write),
        .sweep_new_freq (sweep_new_freq),
        .do_freq_sweep  (do_freq_sweep),
        .freq           (freq),
        .init           (init),
        .duty           (duty),
        .length_enable  (length_enable),
        .enabled        (enabled),
        .duty_pos       (duty_pos),
        .wave_out       (wave_out)
    );

    function automatic int model_wave();
        string s;
        s = pat[m_duty];
        return (s[m_pos] == "1" && m_en != 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int wr11, wr13, wr14, trig, tick, f, old_freq;
        if (reset) begin
            m_freq = 0; m_duty = 0; m_len = 0; m_lenen = 0;
            m_en = 0; m_pos = 0; m_init = 0; m_left = 2048;
            return;
        end
        wr11 = int'(cpu_en && duty_len_write);
        wr13 = int'(cpu_en && freq_lo_write);
        wr14 = int'(cpu_en && freq_hi_write);
        trig = int'(wr14 != 0 && freq_hi_data[7]);
        tick = int'(slow_clk_en && clk256_en && m_lenen != 0 && m_len != 0);
        old_freq = m_freq;
        f = m_freq;
        if (wr13 != 0) f = (f & 'h700) | int'(freq_lo_data);
        if (wr14 != 0) f = (f & 'h0FF) | (int'(freq_hi_data[2:0]) * 256);
        if (wr13 == 0 && wr14 == 0 && do_freq_sweep) f = int'(sweep_new_freq);
        if (trig != 0) begin
            m_left = 2048 - f;
        end else if (slow_clk_en && m_en != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_pos  = (m_pos + 1) % 8;
                m_left = 2048 - old_freq;
            end
        end
        if (wr11 != 0) begin
            m_len = 64 - int'(duty_len_data[5:0]);
        end else if (trig != 0) begin
            if (m_len == 0) m_len = 64;
        end else if (tick != 0) begin
            m_len = m_len - 1;
            if (m_len == 0) m_en = 0;
        end
        if (trig != 0) m_en = 1;
        if (wr11 != 0) m_duty = int'(duty_len_data[7:6]);
        if (wr14 != 0) m_lenen = int'(freq_hi_data[6]);
        m_init = trig;
        m_freq = f;
    endtask

    task automatic compare_all();
        check("freq", int'(freq), m_freq);
        check("init", int'(init), m_init);
        check("duty", int'(duty), m_duty);
        check("length_enable", int'(length_enable), m_lenen);
        check("enabled", int'(enabled), m_en);
        check("duty_pos", int'(duty_pos), m_pos);
        check("wave_out", int'(wave_out), model_wave());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        reset = 1'b0; slow_clk_en = 1'b0; cpu_en = 1'b0; clk256_en = 1'b0;
        duty_len_data = 8'h00; duty_len_write = 1'b0;
        freq_lo_data = 8'h00; freq_lo_write = 1'b0;
        freq_hi_data = 8'h00; freq_hi_write = 1'b0;
        sweep_new_freq = 11'd0; do_freq_sweep = 1'b0;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    task automatic wr_nr11(input logic [7:0] d);
        idle(); cpu_en = 1'b1; duty_len_write = 1'b1; duty_len_data = d; cycle(); idle();
    endtask

    task automatic wr_nr13(input logic [7:0] d);
        idle(); cpu_en = 1'b1; freq_lo_write = 1'b1; freq_lo_data = d; cycle(); idle();
    endtask

    task automatic wr_nr14(input logic [7:0] d);
        idle(); cpu_en = 1'b1; freq_hi_write = 1'b1; freq_hi_data = d; cycle(); idle();
    endtask

    task automatic slow_tick(input logic frame);
        idle(); slow_clk_en = 1'b1; clk256_en = frame; cycle(); idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cycle();
        check("reset_wave", int'(wave_out), 0);
        check("reset_freq", int'(freq), 0);

        // freq 0x534 and the init pulse one clk after the trigger
        wr_nr13(8'h34);
        wr_nr14(8'h85);
        check("t43_freq", int'(freq), 'h534);
        check("t43_init", int'(init), 1);
        cycle();
        check("t43_init_drop", int'(init), 0);

        // CPU write beats a coincident sweep load
        do_reset();
        wr_nr13(8'hFF);
        wr_nr14(8'h03);
        check("t44_pre", int'(freq), 'h3FF);
        idle(); cpu_en = 1'b1; freq_lo_write = 1'b1; freq_lo_data = 8'hAA;
        do_freq_sweep = 1'b1; sweep_new_freq = 11'h100;
        cycle(); idle();
        check("t44_freq", int'(freq), 'h3AA);
        idle(); do_freq_sweep = 1'b1; sweep_new_freq = 11'h100; cycle(); idle();
        check("t44_sweep", int'(freq), 'h100);

        // duty 2 at freq 0x7FE: one step every two ticks
        do_reset();
        wr_nr11(8'h80);
        wr_nr13(8'hFE);
        wr_nr14(8'h87);
        check("t41_freq", int'(freq), 'h7FE);
        check("t41_wave0", int'(wave_out), 1);
        for (int k = 1; k <= 16; k++) begin
            slow_tick(1'b0);
            check("t41_pos", int'(duty_pos), (k / 2) % 8);
            check("t41_wave", int'(wave_out), wave41[(k / 2) % 8]);
        end

        // length 2 expires after two frame ticks
        do_reset();
        wr_nr11(8'h3E);
        wr_nr14(8'hC0);
        slow_tick(1'b1);
        check("t42_en1", int'(enabled), 1);
        slow_tick(1'b1);
        check("t42_en2", int'(enabled), 0);
        check("t42_wave", int'(wave_out), 0);

        // reset mid-operation beats writes, ticks and sweep
        do_reset();
        wr_nr11(8'h36);
        wr_nr13(8'hFF);
        wr_nr14(8'h87);
        for (int k = 0; k < 5; k++) slow_tick(1'b0);
        check("t45_pos5", int'(duty_pos), 5);
        idle(); reset = 1'b1; slow_clk_en = 1'b1; clk256_en = 1'b1; cpu_en = 1'b1;
        freq_hi_write = 1'b1; freq_hi_data = 8'hC7; do_freq_sweep = 1'b1; sweep_new_freq = 11'h555;
        cycle(); idle();
        check("t45_freq", int'(freq), 0);
        check("t45_en", int'(enabled), 0);
        check("t45_init", int'(init), 0);
        for (int k = 0; k < 5; k++) slow_tick(1'b0);
        check("t45_pos", int'(duty_pos), 0);

        // trigger with reset in the same cycle leaves no init pulse
        idle(); reset = 1'b1; cpu_en = 1'b1; freq_hi_write = 1'b1; freq_hi_data = 8'h80;
        cycle(); idle();
        check("t40_init", int'(init), 0);

        // randomized traffic, checked against the model every cycle
        for (int n = 0; n < 4000; n++) begin
            idle();
            reset          = ($urandom_range(0, 399) == 0);
            slow_clk_en    = 1'($urandom_range(0, 1));
            clk256_en      = slow_clk_en && ($urandom_range(0, 7) == 0);
            cpu_en         = ($urandom_range(0, 3) != 0);
            duty_len_write = ($urandom_range(0, 79) == 0);
            duty_len_data  = 8'(($urandom_range(0, 3) << 6) | $urandom_range(40, 63));
            freq_lo_write  = ($urandom_range(0, 39) == 0);
            freq_lo_data   = 8'($urandom);
            freq_hi_write  = ($urandom_range(0, 59) == 0);
            freq_hi_data   = 8'(($urandom & 32'hC0) | $urandom_range(5, 7));
            do_freq_sweep  = ($urandom_range(0, 39) == 0);
            sweep_new_freq = 11'($urandom_range(1536, 2047));
            cycle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
